// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder that serves the instruction-fetch port (i_*) and the
//   data port (d_*) of a processor core from one single-ported, word-addressed
//   RAM. Each access is a req/ack handshake: a port raises req and holds it;
//   the responder grants one port, waits LATENCY cycles and then pulses that
//   port's ack for one cycle with the read data and error flag.
//
//   Parameters
//     DEPTH      number of 32-bit words (valid word addresses 0..DEPTH-1)
//     LATENCY    cycles from grant to ack, legal range 1..15
//     INIT_FILE  RAM image name ("" = none)
//
//   Ports
//     clk, rst                  clock, synchronous active-high reset
//     i_req, i_addr             fetch request (level) and word address
//     i_ack, i_rdata, i_err     fetch completion pulse, data, out-of-range flag
//     d_req, d_we, d_addr,      data request (level), write enable, word address,
//     d_wdata                   write data (we/wdata sampled at grant)
//     d_ack, d_rdata, d_err     data completion pulse, read data, out-of-range flag
//
//   Sequencing is IDLE -> WAIT -> ACK -> IDLE, so one access finishes every
//   LATENCY+2 cycles. When both ports request in IDLE, the port that was not
//   granted last time wins; after reset the fetch port is favoured.
//   Reset does not clear the RAM.

module mem_responder #(
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned LATENCY   = 1,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_START = 4'(LATENCY - 1);
  localparam logic [31:0] DEPTH_W   = 32'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ACK  = 2'b10
  } state_t;

  // Access context latched at grant time
  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        sel_d_q;     // 1 = data port owns the current access
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        last_d_q;    // 1 = data port was granted most recently

  // Registered outputs
  logic        i_ack_q;
  logic [31:0] i_rdata_q;
  logic        i_err_q;
  logic        d_ack_q;
  logic [31:0] d_rdata_q;
  logic        d_err_q;

  logic [31:0] mem [DEPTH];

  logic          grant_d_s;
  logic          in_range_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   rd_word_s;
  logic [31:0]   rd_result_s;
  logic          access_s;
  logic          mem_we_s;

  // Round-robin grant choice and access decode for the latched request
  always_comb begin
    grant_d_s   = 1'b0;
    in_range_s  = 1'b0;
    idx_s       = {AW{1'b0}};
    rd_word_s   = 32'h0000_0000;
    rd_result_s = 32'h0000_0000;
    access_s    = 1'b0;
    mem_we_s    = 1'b0;

    // A lone requester always wins; a tie goes to the port not served last.
    if (d_req && !i_req) begin
      grant_d_s = 1'b1;
    end else if (d_req && i_req) begin
      grant_d_s = ~last_d_q;
    end else begin
      grant_d_s = 1'b0;
    end

    // Full 32-bit range compare: high address bits never alias into the RAM.
    in_range_s = (addr_q < DEPTH_W);
    if (in_range_s) begin
      idx_s = addr_q[AW-1:0];
    end else begin
      idx_s = {AW{1'b0}};
    end

    rd_word_s = mem[idx_s];
    if (in_range_s) begin
      rd_result_s = rd_word_s;
    end else begin
      rd_result_s = 32'h0000_0000;
    end

    access_s = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    // Reset on the access edge abandons a pending write.
    mem_we_s = !rst && access_s && sel_d_q && we_q && in_range_s;
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[idx_s] <= wdata_q;
    end
  end

  // Access sequencer with registered ack/rdata/err outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      sel_d_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0000_0000;
      wdata_q   <= 32'h0000_0000;
      last_d_q  <= 1'b1;         // so the fetch port wins the first tie
      i_ack_q   <= 1'b0;
      i_rdata_q <= 32'h0000_0000;
      i_err_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      d_rdata_q <= 32'h0000_0000;
      d_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          i_ack_q <= 1'b0;
          i_err_q <= 1'b0;
          d_ack_q <= 1'b0;
          d_err_q <= 1'b0;
          if (i_req || d_req) begin
            sel_d_q  <= grant_d_s;
            last_d_q <= grant_d_s;
            addr_q   <= grant_d_s ? d_addr : i_addr;
            we_q     <= grant_d_s & d_we;   // fetches are always reads
            wdata_q  <= d_wdata;
            cnt_q    <= CNT_START;
            state_q  <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= ST_ACK;
            if (sel_d_q) begin
              d_ack_q <= 1'b1;
              d_err_q <= ~in_range_s;
              // Writes leave d_rdata holding its previous read value.
              if (!we_q) begin
                d_rdata_q <= rd_result_s;
              end
            end else begin
              i_ack_q   <= 1'b1;
              i_err_q   <= ~in_range_s;
              i_rdata_q <= rd_result_s;
            end
          end
        end

        ST_ACK: begin
          // req is deliberately ignored here; the requester drops it now.
          i_ack_q <= 1'b0;
          i_err_q <= 1'b0;
          d_ack_q <= 1'b0;
          d_err_q <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          i_ack_q <= 1'b0;
          i_err_q <= 1'b0;
          d_ack_q <= 1'b0;
          d_err_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign i_ack   = i_ack_q;
  assign i_rdata = i_rdata_q;
  assign i_err   = i_err_q;
  assign d_ack   = d_ack_q;
  assign d_rdata = d_rdata_q;
  assign d_err   = d_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder. Three instances (LATENCY 1, 3, 4)
// share the clock, reset and request inputs; each scenario checks one selected
// instance against a reference memory model and the handshake timing rules.

module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;

  logic [2:0]  i_ack_w, i_err_w, d_ack_w, d_err_w;
  logic [31:0] i_rdata_w [3];
  logic [31:0] d_rdata_w [3];

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] ref_mem [int unsigned];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_responder #(
        .DEPTH     (4096),
        .LATENCY   ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
        .INIT_FILE ("")
      ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_ack   (i_ack_w[g]),
        .i_rdata (i_rdata_w[g]),
        .i_err   (i_err_w[g]),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_ack   (d_ack_w[g]),
        .d_rdata (d_rdata_w[g]),
        .d_err   (d_err_w[g])
      );
    end
  endgenerate

  function automatic int lat_of(input int sel);
    return (sel == 0) ? 1 : ((sel == 1) ? 3 : 4);
  endfunction

  task automatic do_reset();
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  // Advance until the selected instance acks or the budget runs out.
  task automatic wait_ack(input int sel, input int budget, output int cyc,
                          output bit gi, output bit gd);
    cyc = 0; gi = 1'b0; gd = 1'b0;
    while (cyc < budget && !gi && !gd) begin
      @(posedge clk); #1;
      cyc++;
      gi = i_ack_w[sel];
      gd = d_ack_w[sel];
    end
  endtask

  // One single-port access; returns timing, ack flags and the acked data/err.
  task automatic access(input int sel, input bit use_d, input bit we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int cyc, output bit gi, output bit gd,
                        output logic [31:0] rd, output logic er);
    if (use_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    wait_ack(sel, 40, cyc, gi, gd);
    rd = use_d ? d_rdata_w[sel] : i_rdata_w[sel];
    er = use_d ? d_err_w[sel] : i_err_w[sel];
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int s = 0; s < 3; s++) begin
      n_cmp++;
      if ({i_ack_w[s], d_ack_w[s], i_err_w[s], d_err_w[s], i_rdata_w[s], d_rdata_w[s]} !== 68'h0) begin
        n_mis++;
        $display("FAIL reset_outputs dut%0d: got ack=%b%b err=%b%b ird=%h drd=%h expected all zero",
                 s, i_ack_w[s], d_ack_w[s], i_err_w[s], d_err_w[s], i_rdata_w[s], d_rdata_w[s]);
      end
    end
  endtask

  task automatic test_fetch_basic();
    int cyc; bit gi, gd; logic [31:0] rd; logic er; bit exp_ack;
    do_reset();
    access(0, 1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF, cyc, gi, gd, rd, er);
    n_cmp++;
    if ({gi, gd, er} !== 3'b010 || cyc != 2) begin
      n_mis++;
      $display("FAIL fetch_setup_write: got gi=%b gd=%b err=%b cyc=%0d expected 0 1 0 cyc=2", gi, gd, er, cyc);
    end
    i_req = 1'b1; i_addr = 32'd5;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      exp_ack = (c == 2);
      n_cmp++;
      if ({i_ack_w[0], i_err_w[0], d_ack_w[0]} !== {exp_ack, 1'b0, 1'b0}) begin
        n_mis++;
        $display("FAIL fetch_ack_pulse c=%0d: got i_ack=%b i_err=%b d_ack=%b expected i_ack=%b 0 0",
                 c, i_ack_w[0], i_err_w[0], d_ack_w[0], exp_ack);
      end
      if (c == 2) begin
        n_cmp++;
        if (i_rdata_w[0] !== 32'hDEAD_BEEF) begin
          n_mis++;
          $display("FAIL fetch_rdata: got %h expected deadbeef", i_rdata_w[0]);
        end
        i_req = 1'b0;
      end
    end
    n_cmp++;
    if (i_rdata_w[0] !== 32'hDEAD_BEEF || d_rdata_w[0] !== 32'h0) begin
      n_mis++;
      $display("FAIL fetch_hold: got ird=%h drd=%h expected deadbeef 00000000", i_rdata_w[0], d_rdata_w[0]);
    end
  endtask

  task automatic test_write_read();
    int cyc; bit gi, gd; logic [31:0] rd; logic er;
    access(0, 1'b1, 1'b1, 32'd9, 32'hA5A5_0001, cyc, gi, gd, rd, er);
    access(0, 1'b1, 1'b0, 32'd9, 32'h0, cyc, gi, gd, rd, er);
    n_cmp++;
    if (!gd || rd !== 32'hA5A5_0001 || er !== 1'b0) begin
      n_mis++;
      $display("FAIL wr_read9: got ack=%b data=%h err=%b expected 1 a5a50001 0", gd, rd, er);
    end
    // Grant the write, then disturb addr/wdata/we and drop req.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd7; d_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    d_addr = 32'd8; d_wdata = 32'hBAD0_BAD0; d_we = 1'b0; d_req = 1'b0;
    wait_ack(0, 20, cyc, gi, gd);
    n_cmp++;
    if (!gd || cyc != 1 || d_err_w[0] !== 1'b0 || d_rdata_w[0] !== 32'hA5A5_0001) begin
      n_mis++;
      $display("FAIL wr_latched_write: got ack=%b cyc=%0d err=%b drd=%h expected 1 1 0 a5a50001",
               gd, cyc, d_err_w[0], d_rdata_w[0]);
    end
    @(posedge clk); #1;
    access(0, 1'b1, 1'b0, 32'd7, 32'h0, cyc, gi, gd, rd, er);
    n_cmp++;
    if (!gd || rd !== 32'h1234_5678 || er !== 1'b0) begin
      n_mis++;
      $display("FAIL wr_read7: got ack=%b data=%h err=%b expected 1 12345678 0", gd, rd, er);
    end
  endtask

  task automatic test_round_robin();
    int nxt [3]; bit exp_d [3]; bit ia, da, exp_now;
    do_reset();
    for (int s = 0; s < 3; s++) begin nxt[s] = lat_of(s) + 1; exp_d[s] = 1'b0; end
    i_addr = 32'd3; d_addr = 32'd4; d_we = 1'b0; i_req = 1'b1; d_req = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      for (int s = 0; s < 3; s++) begin
        ia = i_ack_w[s]; da = d_ack_w[s];
        exp_now = (cyc == nxt[s]);
        n_cmp++;
        if ((ia & da) !== 1'b0 || (ia | da) !== exp_now) begin
          n_mis++;
          $display("FAIL rr_timing dut%0d cyc=%0d: got i_ack=%b d_ack=%b expected one ack=%b", s, cyc, ia, da, exp_now);
        end
        if (exp_now) begin
          if (ia | da) begin
            n_cmp++;
            if (da !== exp_d[s]) begin
              n_mis++;
              $display("FAIL rr_order dut%0d cyc=%0d: got d_port=%b expected %b", s, cyc, da, exp_d[s]);
            end
          end
          exp_d[s] = ~exp_d[s];
          nxt[s] = nxt[s] + lat_of(s) + 2;
        end
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
  endtask

  task automatic test_out_of_range();
    int cyc; bit gi, gd; logic [31:0] rd; logic er;
    access(0, 1'b1, 1'b1, 32'd4095, 32'h0BAD_F00D, cyc, gi, gd, rd, er);
    access(0, 1'b1, 1'b0, 32'd4095, 32'h0, cyc, gi, gd, rd, er);
    access(0, 1'b1, 1'b1, 32'd4096, 32'hFFFF_FFFF, cyc, gi, gd, rd, er);
    n_cmp++;
    if (!gd || er !== 1'b1 || rd !== 32'h0BAD_F00D) begin
      n_mis++;
      $display("FAIL oor_write: got ack=%b err=%b drd=%h expected 1 1 0badf00d", gd, er, rd);
    end
    n_cmp++;
    if (d_ack_w[0] !== 1'b0 || d_err_w[0] !== 1'b0) begin
      n_mis++;
      $display("FAIL oor_err_clear: got ack=%b err=%b expected 0 0", d_ack_w[0], d_err_w[0]);
    end
    access(0, 1'b1, 1'b0, 32'd4095, 32'h0, cyc, gi, gd, rd, er);
    n_cmp++;
    if (!gd || er !== 1'b0 || rd !== 32'h0BAD_F00D) begin
      n_mis++;
      $display("FAIL oor_read_last: got ack=%b err=%b data=%h expected 1 0 0badf00d", gd, er, rd);
    end
    access(0, 1'b1, 1'b0, 32'h0001_0FFF, 32'h0, cyc, gi, gd, rd, er);
    n_cmp++;
    if (!gd || er !== 1'b1 || rd !== 32'h0) begin
      n_mis++;
      $display("FAIL oor_no_wrap: got ack=%b err=%b data=%h expected 1 1 00000000", gd, er, rd);
    end
    access(0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, cyc, gi, gd, rd, er);
    n_cmp++;
    if (!gi || er !== 1'b1 || rd !== 32'h0) begin
      n_mis++;
      $display("FAIL oor_fetch: got ack=%b err=%b data=%h expected 1 1 00000000", gi, er, rd);
    end
  endtask

  task automatic test_reset_in_wait();
    int cyc; bit gi, gd; logic [31:0] rd; logic er; bit seen;
    do_reset();
    access(1, 1'b1, 1'b1, 32'd2, 32'h0000_0055, cyc, gi, gd, rd, er);
    n_cmp++;
    if (!gd || cyc != 4) begin
      n_mis++;
      $display("FAIL rw_setup_write: got ack=%b cyc=%0d expected 1 4", gd, cyc);
    end
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd2; d_wdata = 32'h0000_00AA;
    repeat (3) begin @(posedge clk); #1; end   // grant edge, then two WAIT edges
    rst = 1'b1; d_req = 1'b0;                   // reset lands on the access edge
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({i_ack_w[1], d_ack_w[1], i_err_w[1], d_err_w[1], i_rdata_w[1], d_rdata_w[1]} !== 68'h0) begin
      n_mis++;
      $display("FAIL rw_outputs_zero: got ack=%b%b err=%b%b ird=%h drd=%h expected all zero",
               i_ack_w[1], d_ack_w[1], i_err_w[1], d_err_w[1], i_rdata_w[1], d_rdata_w[1]);
    end
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; seen = seen | d_ack_w[1] | i_ack_w[1]; end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_mis++;
      $display("FAIL rw_no_ack: got ack seen=%b expected 0", seen);
    end
    access(1, 1'b1, 1'b0, 32'd2, 32'h0, cyc, gi, gd, rd, er);
    n_cmp++;
    if (!gd || rd !== 32'h0000_0055 || er !== 1'b0) begin
      n_mis++;
      $display("FAIL rw_write_dropped: got ack=%b data=%h err=%b expected 1 00000055 0", gd, rd, er);
    end
  endtask

  task automatic test_latency4();
    int cyc; bit gi, gd;
    do_reset();
    i_req = 1'b1; i_addr = 32'd1;
    wait_ack(2, 20, cyc, gi, gd);
    n_cmp++;
    if (!gi || gd || cyc != 5) begin
      n_mis++;
      $display("FAIL lat4_first: got i_ack=%b d_ack=%b cyc=%0d expected 1 0 5", gi, gd, cyc);
    end
    wait_ack(2, 20, cyc, gi, gd);
    n_cmp++;
    if (!gi || gd || cyc != 6) begin
      n_mis++;
      $display("FAIL lat4_throughput: got i_ack=%b d_ack=%b cyc=%0d expected 1 0 6", gi, gd, cyc);
    end
    i_req = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'd4096 + 32'($urandom_range(0, 15));
    if (r == 1) return 32'hFFFF_F000 | 32'($urandom_range(0, 15));
    if (r == 2) return 32'd4095;
    return 32'($urandom_range(0, 15));
  endfunction

  task automatic test_random(input int sel);
    int lat, mode, n_exp, cyc; bit gi, gd, last_d, first_d, exp_pd, we, oor;
    logic [31:0] ia, da, wd, exp_drd; bit drd_known;
    lat = lat_of(sel);
    do_reset();
    ref_mem.delete();
    last_d = 1'b1; exp_drd = 32'h0; drd_known = 1'b1;
    for (int t = 0; t < 40; t++) begin
      mode = $urandom_range(0, 2);            // 0 fetch only, 1 data only, 2 both
      ia = rand_addr(); da = rand_addr(); wd = $urandom; we = 1'($urandom_range(0, 1));
      i_addr = ia; d_addr = da; d_we = we; d_wdata = wd;
      i_req = (mode != 1); d_req = (mode != 0);
      n_exp = (mode == 2) ? 2 : 1;
      first_d = (mode == 1) ? 1'b1 : ((mode == 0) ? 1'b0 : ~last_d);
      for (int k = 0; k < n_exp; k++) begin
        exp_pd = (k == 0) ? first_d : ~first_d;
        wait_ack(sel, 3 * lat + 10, cyc, gi, gd);
        n_cmp++;
        if ({gi, gd} !== {~exp_pd, exp_pd} || cyc != ((k == 0) ? lat + 1 : lat + 2)) begin
          n_mis++;
          $display("FAIL rnd_ack t=%0d k=%0d: got i_ack=%b d_ack=%b cyc=%0d expected d_port=%b cyc=%0d",
                   t, k, gi, gd, cyc, exp_pd, (k == 0) ? lat + 1 : lat + 2);
          break;
        end
        last_d = exp_pd;
        if (!exp_pd) begin
          oor = (ia >= 32'd4096);
          n_cmp++;
          if (i_err_w[sel] !== oor || (oor && i_rdata_w[sel] !== 32'h0) ||
              (!oor && ref_mem.exists(ia) && i_rdata_w[sel] !== ref_mem[ia])) begin
            n_mis++;
            $display("FAIL rnd_fetch t=%0d addr=%h: got data=%h err=%b expected err=%b data=%h",
                     t, ia, i_rdata_w[sel], i_err_w[sel], oor,
                     oor ? 32'h0 : (ref_mem.exists(ia) ? ref_mem[ia] : 32'h0));
          end
          i_req = 1'b0;
        end else begin
          oor = (da >= 32'd4096);
          if (we) begin
            n_cmp++;
            if (d_err_w[sel] !== oor || (drd_known && d_rdata_w[sel] !== exp_drd)) begin
              n_mis++;
              $display("FAIL rnd_write t=%0d addr=%h: got err=%b drd=%h expected err=%b drd=%h",
                       t, da, d_err_w[sel], d_rdata_w[sel], oor, exp_drd);
            end
            if (!oor) ref_mem[da] = wd;
          end else begin
            if (oor) begin
              exp_drd = 32'h0; drd_known = 1'b1;
            end else if (ref_mem.exists(da)) begin
              exp_drd = ref_mem[da]; drd_known = 1'b1;
            end else begin
              drd_known = 1'b0;
            end
            n_cmp++;
            if (d_err_w[sel] !== oor || (drd_known && d_rdata_w[sel] !== exp_drd)) begin
              n_mis++;
              $display("FAIL rnd_read t=%0d addr=%h: got err=%b data=%h expected err=%b data=%h",
                       t, da, d_err_w[sel], d_rdata_w[sel], oor, exp_drd);
            end
          end
          d_req = 1'b0;
        end
      end
      i_req = 1'b0; d_req = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if ((i_ack_w[sel] | d_ack_w[sel] | i_err_w[sel] | d_err_w[sel]) !== 1'b0) begin
        n_mis++;
        $display("FAIL rnd_pulse t=%0d: got ack=%b%b err=%b%b expected all 0",
                 t, i_ack_w[sel], d_ack_w[sel], i_err_w[sel], d_err_w[sel]);
      end
      repeat (lat + 2) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_basic();
    test_write_read();
    test_round_robin();
    test_out_of_range();
    test_reset_in_wait();
    test_latency4();
    test_random(1);
    test_random(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
